// File: rtl/vespa_int_pkg.sv
// Shared definitions for the VeSPA interrupt controller: register offsets,
// FSM state encoding, line count and the STATUS register layout.
package vespa_int_pkg;

    // Line count is fixed by the 2-bit CPU interrupt number
    localparam int N_IRQ = 4;

    // Word offsets from the controller base address
    localparam int unsigned REG_MASK    = 0;
    localparam int unsigned REG_PENDING = 1;
    localparam int unsigned REG_STATUS  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } intState_t;

    // STATUS read layout: {28'b0, state[1:0], activeNum[1:0]}
    typedef struct packed {
        logic [27:0] reserved;
        intState_t   state;
        logic [1:0]  activeNum;
    } statusWord_t;

endpackage

// File: rtl/vespa_int_controller_irq_edge_detect.sv
// Per-line two-flop synchroniser followed by a third flop for rising-edge
// detection. Output is a one-cycle pulse per synchronised rising edge.
module irq_edge_detect #(
    parameter int WIDTH = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic [WIDTH-1:0] i_Lines,
    output logic [WIDTH-1:0] o_Edge
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] sync3;

    // Synchroniser chain plus the delayed copy used for edge detection
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= i_Lines;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
        assign o_Edge[gi] = sync2[gi] & ~sync3[gi];
    end

endmodule

// File: rtl/vespa_int_controller.sv
// Memory-mapped interrupt controller for the VeSPA CPU: latches synchronised
// rising edges into a pending register, arbitrates by fixed priority (line 0
// highest) and runs the request/service handshake with the CPU.
module vespa_int_controller #(
    parameter int              DATA_W    = 32,
    parameter logic [DATA_W-1:0] BASE_ADDR = 'h0000_FF00,
    parameter int              N_IRQ     = vespa_int_pkg::N_IRQ
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [N_IRQ-1:0]  i_IrqLines,
    input  logic              i_WEnable,
    input  logic [DATA_W-1:0] i_WAddr,
    input  logic [DATA_W-1:0] i_WData,
    input  logic              i_REnable,
    input  logic [DATA_W-1:0] i_RAddr,
    output logic [DATA_W-1:0] o_RData,
    output logic              o_IntRequest,
    output logic [1:0]        o_IntNumber,
    output logic              o_IntPending,
    input  logic              i_IntAckAttended,
    input  logic              i_IntAckComplete
);

    import vespa_int_pkg::*;

    localparam logic [DATA_W-1:0] MASK_ADDR    = BASE_ADDR + DATA_W'(REG_MASK);
    localparam logic [DATA_W-1:0] PENDING_ADDR = BASE_ADDR + DATA_W'(REG_PENDING);
    localparam logic [DATA_W-1:0] STATUS_ADDR  = BASE_ADDR + DATA_W'(REG_STATUS);

    logic [N_IRQ-1:0] irqEdge;
    logic [N_IRQ-1:0] pendingReg;
    logic [N_IRQ-1:0] pendingNext;
    logic [N_IRQ-1:0] maskReg;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] ackClear;
    logic [N_IRQ-1:0] busClear;
    logic [1:0]       winner;
    logic [1:0]       activeNum;
    intState_t        state;
    statusWord_t      statusWord;
    logic             unusedWData;

    irq_edge_detect #(
        .WIDTH (N_IRQ)
    ) u_edgeDetect (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Lines (i_IrqLines),
        .o_Edge  (irqEdge)
    );

    assign unusedWData = ^i_WData[DATA_W-1:N_IRQ];
    assign eligible    = pendingReg & maskReg;
    assign statusWord  = '{reserved: '0, state: state, activeNum: activeNum};

    // Clears from the CPU accepting the active line and from bus W1C; a
    // coincident new edge takes priority over either clear
    always_comb begin
        ackClear = '0;
        if (state == ST_REQUEST && i_IntAckAttended) begin
            ackClear[activeNum] = 1'b1;
        end
        busClear = '0;
        if (i_WEnable && i_WAddr == PENDING_ADDR) begin
            busClear = i_WData[N_IRQ-1:0];
        end
        pendingNext = (pendingReg & ~(ackClear | busClear)) | irqEdge;
    end

    // Fixed priority: lowest set index wins
    always_comb begin
        winner = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = i[1:0];
            end
        end
    end

    // Pending and mask registers
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            pendingReg <= '0;
            maskReg    <= '0;
        end else begin
            pendingReg <= pendingNext;
            if (i_WEnable && i_WAddr == MASK_ADDR) begin
                maskReg <= i_WData[N_IRQ-1:0];
            end
        end
    end

    // Request/service handshake; once a request is raised it is held until acked
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state        <= ST_IDLE;
            activeNum    <= '0;
            o_IntRequest <= 1'b0;
            o_IntNumber  <= '0;
            o_IntPending <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (eligible != '0) begin
                        state        <= ST_REQUEST;
                        activeNum    <= winner;
                        o_IntRequest <= 1'b1;
                        o_IntNumber  <= winner;
                    end
                end
                ST_REQUEST: begin
                    if (i_IntAckAttended) begin
                        state        <= ST_SERVICE;
                        o_IntRequest <= 1'b0;
                        o_IntPending <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    if (i_IntAckComplete) begin
                        state        <= ST_IDLE;
                        o_IntPending <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    o_IntRequest <= 1'b0;
                    o_IntPending <= 1'b0;
                end
            endcase
        end
    end

    // Registered read port; returns pre-write values and zero when not selected
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_RData <= '0;
        end else if (i_REnable) begin
            case (i_RAddr)
                MASK_ADDR:    o_RData <= {{(DATA_W - N_IRQ){1'b0}}, maskReg};
                PENDING_ADDR: o_RData <= {{(DATA_W - N_IRQ){1'b0}}, pendingReg};
                STATUS_ADDR:  o_RData <= DATA_W'(statusWord);
                default:      o_RData <= '0;
            endcase
        end else begin
            o_RData <= '0;
        end
    end

endmodule
